// File: rtl/msg_sched_stream_pkg.sv
// sha2_pkg: FSM states, small-sigma rotate/shift amounts and round count for SHA-256/512
package sha2_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, GEN} state_e;
  localparam int S256_S0_R0 = 7;
  localparam int S256_S0_R1 = 18;
  localparam int S256_S0_SH = 3;
  localparam int S256_S1_R0 = 17;
  localparam int S256_S1_R1 = 19;
  localparam int S256_S1_SH = 10;
  localparam int S512_S0_R0 = 1;
  localparam int S512_S0_R1 = 8;
  localparam int S512_S0_SH = 7;
  localparam int S512_S1_R0 = 19;
  localparam int S512_S1_R1 = 61;
  localparam int S512_S1_SH = 6;
  function automatic int rounds_of(input int dw);
    return dw == 64 ? 80 : 64;
  endfunction
  function automatic int sig_amt(input int dw, input bit sel, input int k);
    return k == 0 ? (dw == 64 ? (sel ? S512_S1_R0 : S512_S0_R0) : (sel ? S256_S1_R0 : S256_S0_R0)) :
           k == 1 ? (dw == 64 ? (sel ? S512_S1_R1 : S512_S0_R1) : (sel ? S256_S1_R1 : S256_S0_R1)) :
                    (dw == 64 ? (sel ? S512_S1_SH : S512_S0_SH) : (sel ? S256_S1_SH : S256_S0_SH));
  endfunction
endpackage

// File: rtl/msg_sched_stream_if.sv
// msg_sched_stream_if: control, input stream and output stream of the message-schedule generator
interface msg_sched_stream_if #(parameter int DATA_WIDTH = 32);
  logic                  start_in;
  logic                  abort_in;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [6:0]            round_out;
  logic                  done_out;
  modport master (output start_in, abort_in, in_data, in_valid, out_ready,
                  input in_ready, out_data, out_valid, round_out, done_out);
  modport slave (input start_in, abort_in, in_data, in_valid, out_ready,
                 output in_ready, out_data, out_valid, round_out, done_out);
endinterface

// File: rtl/msg_sched_stream_sigma.sv
// sha2_small_sigma: SHA-2 small sigma (SEL=0 sigma0, SEL=1 sigma1); x_i word in, y_o sigma out
module sha2_small_sigma
  import sha2_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter bit SEL        = 1'b0
) (
  input  logic [DATA_WIDTH-1:0] x_i,
  output logic [DATA_WIDTH-1:0] y_o
);
  localparam int R0 = sig_amt(DATA_WIDTH, SEL, 0);
  localparam int R1 = sig_amt(DATA_WIDTH, SEL, 1);
  localparam int SH = sig_amt(DATA_WIDTH, SEL, 2);
  assign y_o = (x_i >> R0 | x_i << (DATA_WIDTH - R0)) ^
               (x_i >> R1 | x_i << (DATA_WIDTH - R1)) ^
               (x_i >> SH);
endmodule

// File: rtl/msg_sched_stream.sv
// msg_sched_stream: loads 16 message words, then streams W[0..ROUNDS-1] from a 16-word circular window; ports clk, rst, sched_io (slave)
module msg_sched_stream
  import sha2_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input logic               clk,
  input logic               rst,
  msg_sched_stream_if.slave sched_io
);
  localparam int         ROUNDS = rounds_of(DATA_WIDTH);
  localparam logic [6:0] LAST   = 7'(ROUNDS - 1);
  if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_width
    $error("msg_sched_stream: DATA_WIDTH must be 32 or 64");
  end
  state_e                state_q, state_d;
  logic [3:0]            lc_q, lc_d;
  logic [6:0]            t_q, t_d;
  logic [DATA_WIDTH-1:0] win_q [16];
  logic                  in_ready_q, out_valid_q, done_q, done_d;
  logic                  wr_en;
  logic [3:0]            wr_addr;
  logic [DATA_WIDTH-1:0] wr_data, s0, s1, sum;
  logic [3:0]            ti;
  assign ti = t_q[3:0];
  sha2_small_sigma #(.DATA_WIDTH(DATA_WIDTH), .SEL(1'b0)) u_s0 (.x_i(win_q[ti + 4'd1]), .y_o(s0));
  sha2_small_sigma #(.DATA_WIDTH(DATA_WIDTH), .SEL(1'b1)) u_s1 (.x_i(win_q[ti + 4'd14]), .y_o(s1));
  // win[t] still holds W[t-16]; t+1, t+9, t+14 hold W[t-15], W[t-7], W[t-2]
  assign sum                = win_q[ti] + s0 + win_q[ti + 4'd9] + s1;
  assign sched_io.out_data  = t_q < 7'd16 ? win_q[ti] : sum;
  assign sched_io.in_ready  = in_ready_q;
  assign sched_io.out_valid = out_valid_q;
  assign sched_io.round_out = t_q;
  assign sched_io.done_out  = done_q;
  always_comb begin
    state_d = state_q;
    lc_d    = lc_q;
    t_d     = t_q;
    done_d  = 1'b0;
    wr_en   = 1'b0;
    wr_addr = lc_q;
    wr_data = sched_io.in_data;
    if (state_q == IDLE) begin
      if (sched_io.start_in) begin
        state_d = LOAD;
        lc_d    = 4'd0;
        t_d     = 7'd0;
      end
    end else if (sched_io.abort_in) begin
      state_d = IDLE;
    end else if (state_q == LOAD && sched_io.in_valid && in_ready_q) begin
      wr_en   = 1'b1;
      lc_d    = lc_q + 4'd1;
      state_d = lc_q == 4'd15 ? GEN : LOAD;
    end else if (state_q == GEN && sched_io.out_ready && out_valid_q) begin
      wr_en   = t_q >= 7'd16;
      wr_addr = ti;
      wr_data = sum;
      // round_out holds the final index once the block completes
      t_d     = t_q == LAST ? t_q : t_q + 7'd1;
      state_d = t_q == LAST ? IDLE : GEN;
      done_d  = t_q == LAST;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      lc_q        <= 4'd0;
      t_q         <= 7'd0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      for (int i = 0; i < 16; i++) win_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      lc_q        <= lc_d;
      t_q         <= t_d;
      in_ready_q  <= state_d == LOAD;
      out_valid_q <= state_d == GEN;
      done_q      <= done_d;
      if (wr_en) win_q[wr_addr] <= wr_data;
    end
  end
endmodule
